dram_512_streamer: RTL and testbench
====================================

Name: dram_512_streamer

Overview:
- Bus initiator for the 256K x 8 banked data memory (18-bit byte address, 8-bit data, single write enable, registered read).
- LOAD mode: takes a byte stream from the UART receiver and writes it to consecutive memory addresses.
- DUMP mode: reads consecutive addresses and pushes each byte to the UART transmitter with a start/busy handshake.
- Sits between the UART RX/TX blocks and the memory, so images can be loaded before downsampling and results read back afterwards.

Parameters:
- ADDR_W, 18, memory byte-address width; depth = 2**ADDR_W.
- READ_LATENCY, 1, clocks from address presented to valid mem_q; legal range 1..3.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start_load  in  1  one-cycle pulse; begin LOAD (sampled in IDLE only)
- start_dump  in  1  one-cycle pulse; begin DUMP (sampled in IDLE only)
- base_addr  in  ADDR_W  first address, captured at start
- length  in  ADDR_W+1  byte count, captured at start; values above depth saturate to depth
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit, held stable from tx_start until the next byte is launched
- tx_start  out  1  one-cycle pulse launching a transmit
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start
- mem_address  out  ADDR_W  memory address
- mem_data  out  8  memory write data
- mem_wren  out  1  memory write enable
- mem_q  in  8  memory read data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at transfer end
- checksum  out  8  see Optional Feature

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Address and count registers cleared.
- Reset asserted in any state aborts the transfer at the next edge, with no done pulse and mem_wren 0 that cycle.
- IDLE:
  - start_load has priority over start_dump when both are asserted.
  - On a start pulse, capture ptr=base_addr and remaining=min(length, depth).
  - If remaining=0, go to FINISH directly; otherwise go to LOAD_WAIT or RD_ISSUE.
- LOAD_WAIT:
  - On rx_valid, register mem_address=ptr, mem_data=rx_data, mem_wren=1 for exactly one cycle.
  - On that same edge, ptr increments and remaining decrements.
  - rx_valid outside LOAD_WAIT is ignored.
  - When remaining reaches 0, go to FINISH.
  - Any rx_valid arriving during the write cycle is also accepted; no bytes are lost at one byte per clock.
- RD_ISSUE:
  - Drive mem_address=ptr with mem_wren=0.
  - Load the latency counter with READ_LATENCY, then go to RD_WAIT.
- RD_WAIT:
  - Count down the latency counter.
  - When it expires, capture mem_q into tx_data and go to TX_LAUNCH.
- TX_LAUNCH:
  - If tx_busy=0, pulse tx_start and go to TX_GAP.
  - Otherwise hold until tx_busy=0.
- TX_GAP: one cycle only, to ignore tx_busy rise latency.
- TX_WAIT:
  - Wait for tx_busy=0.
  - Then increment ptr and decrement remaining.
  - Go to FINISH if remaining=0, else RD_ISSUE.
- FINISH: pulse done for 1 cycle, then return to IDLE. busy drops in the same cycle that done is high.
- Address arithmetic:
  - ptr is modulo depth: 0x3FFFF+1 wraps to 0x00000.
  - Bank boundaries (0x0FFFF to 0x10000, etc.) need no special handling.
- mem_wren is never asserted in DUMP states. mem_address holds its last value in IDLE.
- start pulses while busy=1 are ignored.

Optional Feature:
- Macro: DRAM_STREAM_CHECKSUM_EN.
- When defined:
  - checksum is an 8-bit modulo-256 sum of every byte written (LOAD) or every byte launched to tx_data (DUMP).
  - It is cleared at each accepted start and is valid from the done pulse until the next start.
- When undefined: checksum is tied to 0 and no adder logic is generated.

Test Plan:
- LOAD base=0x00000, length=4, rx bytes 0x11,0x22,0x33,0x44 (spaced 10 clocks) -> four single-cycle mem_wren at addresses 0..3 with matching data; done 1 cycle after the 4th write; checksum=0xAA when the macro is defined.
- DUMP base=0x00000, length=4 after the above, with a TX model holding busy 20 clocks -> tx_start ×4 with tx_data 0x11,0x22,0x33,0x44 in order; no tx_start while tx_busy=1; mem_wren stays 0.
- Bank crossing: LOAD base=0x0FFFE, length=4 -> writes at 0x0FFFE, 0x0FFFF, 0x10000, 0x10001; DUMP returns the same data. Repeat for READ_LATENCY=1,2,3.
- Wrap and saturate: LOAD base=0x3FFFF, length=2 -> writes at 0x3FFFF then 0x00000. length=0x7FFFF -> remaining=0x40000.
- length=0 -> done pulse 2 clocks after start, with no mem_wren and no tx_start. start_load and start_dump in the same cycle -> LOAD runs.
- Reset asserted mid-DUMP (during TX_WAIT) -> next cycle busy=0, tx_start=0, mem_wren=0, no done; a new DUMP then runs normally from its base_addr.

Source files
------------

// File: rtl/dram_512_streamer.sv
// Streams UART bytes into the banked data memory (LOAD) or memory bytes out to the UART (DUMP).
// Optional running byte checksum on o_checksum is enabled by defining DRAM_STREAM_CHECKSUM_EN.
module dram_512_streamer #(
  parameter int ADDR_W       = 18,
  parameter int READ_LATENCY = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start_load,
  input  logic              i_start_dump,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [7:0]        o_mem_data,
  output logic              o_mem_wren,
  input  logic [7:0]        i_mem_q,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_checksum
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);
  localparam logic [1:0]      LAT     = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_WAIT, S_RD_ISSUE, S_RD_WAIT,
    S_TX_LAUNCH, S_TX_GAP, S_TX_WAIT, S_FINISH
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_ptr, w_ptr;
  logic [ADDR_W:0]     r_remaining, w_remaining;
  logic [1:0]          r_lat_cnt, w_lat_cnt;
  logic [7:0]          r_tx_data, w_tx_data;
  logic                r_tx_start, w_tx_start;
  logic [ADDR_W-1:0]   r_mem_address, w_mem_address;
  logic [7:0]          r_mem_data, w_mem_data;
  logic                r_mem_wren, w_mem_wren;
  logic                r_done, w_done;
  logic [ADDR_W:0]     w_len_sat;
  logic                w_start;

  assign w_start   = i_start_load | i_start_dump;
  assign w_len_sat = (i_length > DEPTH) ? DEPTH : i_length;

  always_comb begin
    // NOTE: every next-value signal is defaulted first so no path leaves one unassigned (no latches).
    w_state       = r_state;
    w_ptr         = r_ptr;
    w_remaining   = r_remaining;
    w_lat_cnt     = r_lat_cnt;
    w_tx_data     = r_tx_data;
    w_tx_start    = 1'b0;
    w_mem_address = r_mem_address;
    w_mem_data    = r_mem_data;
    w_mem_wren    = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_ptr       = i_base_addr;
          w_remaining = w_len_sat;
          if (w_len_sat == '0)   w_state = S_FINISH;
          else if (i_start_load) w_state = S_LOAD_WAIT;
          else                   w_state = S_RD_ISSUE;
        end
      end
      S_LOAD_WAIT: begin
        if (i_rx_valid) begin
          w_mem_address = r_ptr;
          w_mem_data    = i_rx_data;
          w_mem_wren    = 1'b1;
          w_ptr         = r_ptr + 1'b1;
          w_remaining   = r_remaining - 1'b1;
          if (r_remaining == REM_ONE) w_state = S_FINISH;
        end
      end
      S_RD_ISSUE: begin
        w_mem_address = r_ptr;
        w_lat_cnt     = LAT;
        w_state       = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Counter starts at READ_LATENCY in the cycle the address is first visible.
        if (r_lat_cnt == 2'd0) begin
          w_tx_data = i_mem_q;
          w_state   = S_TX_LAUNCH;
        end else begin
          w_lat_cnt = r_lat_cnt - 1'b1;
        end
      end
      S_TX_LAUNCH: begin
        if (!i_tx_busy) begin
          w_tx_start = 1'b1;
          w_state    = S_TX_GAP;
        end
      end
      S_TX_GAP: w_state = S_TX_WAIT;
      S_TX_WAIT: begin
        if (!i_tx_busy) begin
          w_ptr       = r_ptr + 1'b1;
          w_remaining = r_remaining - 1'b1;
          w_state     = (r_remaining == REM_ONE) ? S_FINISH : S_RD_ISSUE;
        end
      end
      S_FINISH: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_remaining   <= '0;
      r_lat_cnt     <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_ptr         <= w_ptr;
      r_remaining   <= w_remaining;
      r_lat_cnt     <= w_lat_cnt;
      r_tx_data     <= w_tx_data;
      r_tx_start    <= w_tx_start;
      r_mem_address <= w_mem_address;
      r_mem_data    <= w_mem_data;
      r_mem_wren    <= w_mem_wren;
      r_done        <= w_done;
    end
  end

`ifdef DRAM_STREAM_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_checksum <= '0;
    end else if (r_state == S_IDLE && w_start) begin
      r_checksum <= '0;
    end else if (r_state == S_LOAD_WAIT && i_rx_valid) begin
      r_checksum <= r_checksum + i_rx_data;
    end else if (r_state == S_TX_LAUNCH && !i_tx_busy) begin
      r_checksum <= r_checksum + r_tx_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 8'h00;
`endif

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_mem_address = r_mem_address;
  assign o_mem_data    = r_mem_data;
  assign o_mem_wren    = r_mem_wren;

endmodule

// File: tb/tb_dram_512_streamer.sv
// Self-checking bench: three streamers (READ_LATENCY 1..3) share stimulus; each has its own memory and UART TX model.
module tb_dram_512_streamer;

  localparam int AW      = 18;
  localparam int N       = 3;
  localparam int DEPTH   = 1 << AW;
  localparam int TX_HOLD = 20;

  logic          clk = 1'b0;
  logic          rst, start_load, start_dump, rx_valid;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [7:0]    rx_data;

  logic [7:0]    tx_data     [N];
  logic          tx_start    [N];
  logic          tx_busy     [N];
  logic [AW-1:0] mem_address [N];
  logic [7:0]    mem_data    [N];
  logic          mem_wren    [N];
  logic [7:0]    mem_q       [N];
  logic          busy        [N];
  logic          done        [N];
  logic [7:0]    checksum    [N];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int done_cnt    [N] = '{default: 0};
  int done_cyc    [N] = '{default: 0};
  int last_wr_cyc [N] = '{default: 0};
  int viol        [N] = '{default: 0};
  int wr_base [N];
  int tx_base [N];
  int dc_base [N];
  logic [AW+7:0] wr_q [N][$];
  logic [7:0]    tx_q [N][$];
  logic [7:0]    ref_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [7:0] mem [DEPTH];
    logic [7:0] q_pipe [g+1];
    int busy_left = 0;

    dram_512_streamer #(.ADDR_W(AW), .READ_LATENCY(g + 1)) u_dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_start_load  (start_load),
      .i_start_dump  (start_dump),
      .i_base_addr   (base_addr),
      .i_length      (length),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .o_tx_data     (tx_data[g]),
      .o_tx_start    (tx_start[g]),
      .i_tx_busy     (tx_busy[g]),
      .o_mem_address (mem_address[g]),
      .o_mem_data    (mem_data[g]),
      .o_mem_wren    (mem_wren[g]),
      .i_mem_q       (mem_q[g]),
      .o_busy        (busy[g]),
      .o_done        (done[g]),
      .o_checksum    (checksum[g])
    );

    always @(posedge clk) begin
      if (mem_wren[g] === 1'b1) mem[mem_address[g]] <= mem_data[g];
      q_pipe[0] <= mem[mem_address[g]];
      for (int k = 1; k <= g; k++) q_pipe[k] <= q_pipe[k-1];
      if (tx_start[g] === 1'b1) busy_left <= TX_HOLD;
      else if (busy_left > 0)   busy_left <= busy_left - 1;
    end
    assign mem_q[g]   = q_pipe[g];
    assign tx_busy[g] = (busy_left > 0);

    always @(negedge clk) begin
      if (mem_wren[g] === 1'b1) begin
        wr_q[g].push_back({mem_address[g], mem_data[g]});
        last_wr_cyc[g] = cyc;
      end
      if (tx_start[g] === 1'b1) begin
        tx_q[g].push_back(tx_data[g]);
        if (tx_busy[g]) viol[g]++;
      end
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        done_cyc[g] = cyc;
      end
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_sum(logic [7:0] b [$]);
    logic [7:0] s = 8'h00;
    foreach (b[k]) s = s + b[k];
`ifdef DRAM_STREAM_CHECKSUM_EN
    return s;
`else
    return (s == s) ? 8'h00 : 8'h00;
`endif
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (done_cnt[i] <= dc_base[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic snap();
    for (int i = 0; i < N; i++) begin
      wr_base[i] = wr_q[i].size();
      tx_base[i] = tx_q[i].size();
      dc_base[i] = done_cnt[i];
    end
  endtask

  task automatic start(bit ld, bit dp, int base, int len);
    base_addr  = AW'(base);
    length     = (AW+1)'(len);
    start_load = ld;
    start_dump = dp;
    start_cyc  = cyc;
    tick();
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask

  task automatic send_rx(logic [7:0] b, int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_all_done(string tag, int budget);
    int k = 0;
    while (!all_done() && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(all_done()), 32'd1);
    tick();
  endtask

  task automatic do_load(string tag, int base, logic [7:0] bytes [$], int gap, bit both, bit poke);
    logic [AW-1:0] a;
    snap();
    start(1'b1, both, base, bytes.size());
    foreach (bytes[j]) begin
      send_rx(bytes[j], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
      if (poke && j == 1) start(1'b0, 1'b1, 'h200, 9);
    end
    wait_all_done(tag, 200);
    foreach (bytes[j]) ref_mem[(base + j) % DEPTH] = bytes[j];
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_l%0d_nwr", tag, i + 1), 32'(wr_q[i].size() - wr_base[i]), 32'(bytes.size()));
      foreach (bytes[j]) begin
        a = AW'((base + j) % DEPTH);
        if (wr_base[i] + j < wr_q[i].size())
          check($sformatf("%s_l%0d_wr%0d", tag, i + 1, j), 32'(wr_q[i][wr_base[i] + j]), 32'({a, bytes[j]}));
      end
      check($sformatf("%s_l%0d_ntx", tag, i + 1), 32'(tx_q[i].size() - tx_base[i]), 32'd0);
      check($sformatf("%s_l%0d_ndone", tag, i + 1), 32'(done_cnt[i] - dc_base[i]), 32'd1);
      check($sformatf("%s_l%0d_csum", tag, i + 1), 32'(checksum[i]), 32'(exp_sum(bytes)));
      if (bytes.size() > 0)
        check($sformatf("%s_l%0d_done_lat", tag, i + 1), 32'(done_cyc[i]), 32'(last_wr_cyc[i] + 1));
    end
  endtask

  task automatic do_dump(string tag, int base, int len);
    logic [7:0] exp_b [$];
    for (int j = 0; j < len; j++) exp_b.push_back(ref_mem[(base + j) % DEPTH]);
    snap();
    start(1'b0, 1'b1, base, len);
    wait_all_done(tag, 100 + 40 * len);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_l%0d_ntx", tag, i + 1), 32'(tx_q[i].size() - tx_base[i]), 32'(len));
      foreach (exp_b[j])
        if (tx_base[i] + j < tx_q[i].size())
          check($sformatf("%s_l%0d_tx%0d", tag, i + 1, j), 32'(tx_q[i][tx_base[i] + j]), 32'(exp_b[j]));
      check($sformatf("%s_l%0d_nwr", tag, i + 1), 32'(wr_q[i].size() - wr_base[i]), 32'd0);
      check($sformatf("%s_l%0d_busyviol", tag, i + 1), 32'(viol[i]), 32'd0);
      check($sformatf("%s_l%0d_ndone", tag, i + 1), 32'(done_cnt[i] - dc_base[i]), 32'd1);
      check($sformatf("%s_l%0d_csum", tag, i + 1), 32'(checksum[i]), 32'(exp_sum(exp_b)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bytes [$];
    int base, len;

    rst = 1'b1; start_load = 1'b0; start_dump = 1'b0; rx_valid = 1'b0;
    base_addr = '0; length = '0; rx_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_ctl_l%0d", i + 1), 32'({busy[i], done[i], tx_start[i], mem_wren[i]}), 32'd0);
      check($sformatf("reset_data_l%0d", i + 1), 32'({mem_address[i], tx_data[i]}), 32'd0);
      check($sformatf("reset_csum_l%0d", i + 1), 32'(checksum[i]), 32'd0);
    end

    // Directed load/dump, with an ignored start pulse mid-load
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load("load0", 0, bytes, 10, 1'b0, 1'b1);
    do_dump("dump0", 0, 4);

    // Bank crossing
    bytes = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    do_load("bank_load", 'h0FFFE, bytes, 0, 1'b0, 1'b0);
    do_dump("bank_dump", 'h0FFFE, 4);

    // Address wrap
    bytes = '{8'hDE, 8'hAD};
    do_load("wrap_load", 'h3FFFF, bytes, 1, 1'b0, 1'b0);
    do_dump("wrap_dump", 'h3FFFF, 2);

    // Zero length: done two clocks after start, nothing transferred
    snap();
    start(1'b1, 1'b0, 'h1234, 0);
    wait_all_done("zero_load", 20);
    for (int i = 0; i < N; i++) begin
      check($sformatf("zero_load_l%0d_lat", i + 1), 32'(done_cyc[i]), 32'(start_cyc + 2));
      check($sformatf("zero_load_l%0d_nwr", i + 1), 32'(wr_q[i].size() - wr_base[i]), 32'd0);
    end
    snap();
    start(1'b0, 1'b1, 'h1234, 0);
    wait_all_done("zero_dump", 20);
    for (int i = 0; i < N; i++) begin
      check($sformatf("zero_dump_l%0d_lat", i + 1), 32'(done_cyc[i]), 32'(start_cyc + 2));
      check($sformatf("zero_dump_l%0d_ntx", i + 1), 32'(tx_q[i].size() - tx_base[i]), 32'd0);
    end

    // Simultaneous starts: LOAD wins
    bytes = '{8'h77};
    do_load("both_start", 'h100, bytes, 2, 1'b1, 1'b0);

    // Length saturation, then abort by reset with no done
    snap();
    start(1'b1, 1'b0, 5, 'h7FFFF);
    check("sat_remaining_l1", 32'(g_dut[0].u_dut.r_remaining), 32'h40000);
    check("sat_remaining_l3", 32'(g_dut[2].u_dut.r_remaining), 32'h40000);
    check("sat_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("sat_abort_l%0d_busy", i + 1), 32'(busy[i]), 32'd0);
      check($sformatf("sat_abort_l%0d_ndone", i + 1), 32'(done_cnt[i] - dc_base[i]), 32'd0);
    end

    // Randomized load/dump round trips
    for (int r = 0; r < 6; r++) begin
      base = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(1, 5));
      bytes.delete();
      for (int j = 0; j < len; j++) bytes.push_back(8'($urandom));
      do_load($sformatf("rnd%0d_load", r), base, bytes, -1, 1'b0, 1'b0);
      do_dump($sformatf("rnd%0d_dump", r), base, len);
    end

    // Reset during TX_WAIT aborts the dump cleanly
    snap();
    start(1'b0, 1'b1, 0, 4);
    begin
      int k = 0;
      while (tx_busy[0] !== 1'b1 && k < 100) begin
        tick();
        k++;
      end
      check("midrst_tx_busy_seen", 32'(tx_busy[0]), 32'd1);
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++)
      check($sformatf("midrst_l%0d_outs", i + 1), 32'({busy[i], tx_start[i], mem_wren[i], done[i]}), 32'd0);
    rst = 1'b0;
    repeat (30) tick();
    for (int i = 0; i < N; i++)
      check($sformatf("midrst_l%0d_ndone", i + 1), 32'(done_cnt[i] - dc_base[i]), 32'd0);
    do_dump("post_rst_dump", 'h0FFFE, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
